filter_coef_sequencer: RTL and testbench

- Drives the serial coefficient-load and start/done interface of the 12-coefficient lattice/biquad FILTER block, one sample at a time.
- Upstream (allophone/frame controller) writes 10-bit two's-complement coefficients into a shadow bank and commits them.
- The block converts committed coefficients to sign-magnitude and shifts them into FILTER between samples.
- Per sample strobe it launches one filter computation and returns the filtered sample.

---
 rtl/filter_coef_sequencer.sv | 151 +++++++++++++++
 tb/tb_filter_coef_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_coef_sequencer.sv
// Coefficient sequencer for the 12-coefficient FILTER block. Holds shadow/active coefficient
// banks, shifts sign-magnitude coefficients into FILTER and launches one computation per sample.
module filter_coef_sequencer #(
  parameter int unsigned NCOEF  = 12,
  parameter int unsigned COEF_W = 10,
  parameter int unsigned SIG_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_an,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_idx,
  input  logic [COEF_W-1:0] i_wr_data,
  input  logic              i_commit,
  input  logic              i_sample_stb,
  input  logic [SIG_W-1:0]  i_src_in,
  output logic [COEF_W-1:0] o_coef_out,
  output logic              o_coef_load,
  output logic [SIG_W-1:0]  o_filt_sig_in,
  output logic              o_filt_start,
  input  logic              i_filt_done,
  input  logic [SIG_W-1:0]  i_filt_sig_out,
  output logic [SIG_W-1:0]  o_sample_out,
  output logic              o_sample_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] NCOEF_IDX = CNT_W'(NCOEF);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NCOEF - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StWait} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [COEF_W-1:0]   r_shadow [NCOEF];
  logic [COEF_W-1:0]   r_active [NCOEF];
  logic                r_pending;
  logic                r_commit_held;
  logic [CNT_W-1:0]    r_cnt;
  logic [SIG_W-1:0]    r_filt_sig;
  logic [SIG_W-1:0]    r_sample_out;
  logic                r_sample_valid;
  logic                r_overrun;
  logic [COEF_W-1:0]   w_coef_raw;
  logic [COEF_W-1:0]   w_coef_neg;
  logic [COEF_W-1:0]   w_coef_sm;
  logic                w_load_last;

  assign w_coef_raw  = r_active[r_cnt];
  assign w_coef_neg  = -w_coef_raw;
  assign w_load_last = (r_state == StLoad) && (r_cnt == LAST_IDX);

  // Two's complement to sign-magnitude; the most negative value has no magnitude and saturates.
  always_comb begin
    if (!w_coef_raw[COEF_W-1]) begin
      w_coef_sm = w_coef_raw;
    end else if (w_coef_neg[COEF_W-1]) begin
      w_coef_sm = '1;
    end else begin
      w_coef_sm = {1'b1, w_coef_neg[COEF_W-2:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_sample_stb) w_state_next = r_pending ? StLoad : StRun;
      StLoad:  if (r_cnt == LAST_IDX) w_state_next = StRun;
      StRun:   w_state_next = StWait;
      StWait:  if (i_filt_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_coef_load  = 1'b0;
    o_coef_out   = '0;
    o_filt_start = 1'b0;
    o_busy       = (r_state != StIdle);
    unique case (r_state)
      StLoad: begin
        o_coef_load = 1'b1;
        o_coef_out  = w_coef_sm;
      end
      StRun:   o_filt_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_shadow       <= '{default: '0};
      r_active       <= '{default: '0};
      r_pending      <= 1'b0;
      r_commit_held  <= 1'b0;
      r_cnt          <= '0;
      r_filt_sig     <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (i_wr_en && (i_wr_idx < NCOEF_IDX)) begin
        r_shadow[i_wr_idx] <= i_wr_data;
      end
      // The active bank is frozen while shifting; a commit seen mid-load lands as LOAD exits.
      if (r_state == StLoad) begin
        if (w_load_last) begin
          r_cnt         <= '0;
          r_commit_held <= 1'b0;
          if (i_commit || r_commit_held) begin
            r_active  <= r_shadow;
            r_pending <= 1'b1;
          end else begin
            r_pending <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (i_commit) r_commit_held <= 1'b1;
        end
      end else if (i_commit) begin
        r_active  <= r_shadow;
        r_pending <= 1'b1;
      end
      if ((r_state == StIdle) && i_sample_stb) begin
        r_filt_sig <= i_src_in;
      end
      if ((r_state != StIdle) && i_sample_stb) begin
        r_overrun <= 1'b1;
      end
      r_sample_valid <= (r_state == StWait) && i_filt_done;
      if ((r_state == StWait) && i_filt_done) begin
        r_sample_out <= i_filt_sig_out;
      end
    end
  end

  assign o_filt_sig_in  = r_filt_sig;
  assign o_sample_out   = r_sample_out;
  assign o_sample_valid = r_sample_valid;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_filter_coef_sequencer.sv
// Self-checking bench for filter_coef_sequencer: scoreboard queues filled at stimulus time,
// drained by a negedge monitor; a small FILTER model answers filt_start with filt_done.
module tb_filter_coef_sequencer;

  localparam int NCOEF  = 12;
  localparam int COEF_W = 10;
  localparam int SIG_W  = 16;

  logic              clk = 1'b0;
  logic              rst_an = 1'b0;
  logic              wr_en = 1'b0;
  logic [3:0]        wr_idx = '0;
  logic [COEF_W-1:0] wr_data = '0;
  logic              commit = 1'b0;
  logic              sample_stb = 1'b0;
  logic [SIG_W-1:0]  src_in = '0;
  logic              filt_done = 1'b0;
  logic [SIG_W-1:0]  filt_sig_out = '0;
  logic [COEF_W-1:0] coef_out;
  logic              coef_load;
  logic [SIG_W-1:0]  filt_sig_in;
  logic              filt_start;
  logic [SIG_W-1:0]  sample_out;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  filter_coef_sequencer #(
    .NCOEF  (NCOEF),
    .COEF_W (COEF_W),
    .SIG_W  (SIG_W)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_an       (rst_an),
    .i_wr_en        (wr_en),
    .i_wr_idx       (wr_idx),
    .i_wr_data      (wr_data),
    .i_commit       (commit),
    .i_sample_stb   (sample_stb),
    .i_src_in       (src_in),
    .o_coef_out     (coef_out),
    .o_coef_load    (coef_load),
    .o_filt_sig_in  (filt_sig_in),
    .o_filt_start   (filt_start),
    .i_filt_done    (filt_done),
    .i_filt_sig_out (filt_sig_out),
    .o_sample_out   (sample_out),
    .o_sample_valid (sample_valid),
    .o_busy         (busy),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [COEF_W-1:0] q_coef[$];
  int                q_coef_cyc[$];
  int                q_start_cyc[$];
  logic [SIG_W-1:0]  q_sig[$];
  logic [SIG_W-1:0]  q_resp[$];
  logic [SIG_W-1:0]  q_sample[$];

  logic [COEF_W-1:0] m_shadow [NCOEF];
  logic [COEF_W-1:0] m_active [NCOEF];
  bit                m_pending;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [COEF_W-1:0] to_sm(input logic [COEF_W-1:0] v);
    int sv;
    sv = $signed(v);
    if (sv >= 0) return v;
    if (sv == -512) return 10'h3FF;
    return 10'(512 + (-sv));
  endfunction

  always @(negedge clk) begin
    if (coef_load === 1'b1) begin
      if (q_coef.size() == 0) check("coef_unexp", coef_load, 0);
      else begin
        check("coef_val", coef_out, q_coef.pop_front());
        check("coef_cyc", cyc, q_coef_cyc.pop_front());
      end
    end else begin
      check("coef_idle", coef_out, 0);
    end
    if (filt_start === 1'b1) begin
      if (q_start_cyc.size() == 0) check("start_unexp", filt_start, 0);
      else begin
        check("start_cyc", cyc, q_start_cyc.pop_front());
        check("filt_sig_in", filt_sig_in, q_sig.pop_front());
      end
    end
    if (sample_valid === 1'b1) begin
      if (q_sample.size() == 0) check("valid_unexp", sample_valid, 0);
      else check("sample_out", sample_out, q_sample.pop_front());
    end
  end

  // FILTER model: answers two cycles after each start, checks its input held steady meanwhile.
  initial begin : filter_model
    logic [SIG_W-1:0] held;
    forever begin
      @(negedge clk);
      if (filt_start === 1'b1) begin
        held = filt_sig_in;
        repeat (2) @(negedge clk);
        filt_done    = 1'b1;
        filt_sig_out = (q_resp.size() != 0) ? q_resp.pop_front() : 16'hDEAD;
        check("sig_in_stable", filt_sig_in, held);
        @(negedge clk);
        filt_done    = 1'b0;
        filt_sig_out = '0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_an = 1'b0;
    tick();
    check("rst_coef_out", coef_out, 0);
    check("rst_flags", {coef_load, filt_start, sample_valid, busy, overrun}, 0);
    check("rst_filt_sig_in", filt_sig_in, 0);
    check("rst_sample_out", sample_out, 0);
    q_coef.delete(); q_coef_cyc.delete(); q_start_cyc.delete();
    q_sig.delete(); q_resp.delete(); q_sample.delete();
    for (int i = 0; i < NCOEF; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 1'b0;
    tick();
    rst_an = 1'b1;
    tick();
  endtask

  task automatic write(input int idx, input logic [COEF_W-1:0] d);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (idx < NCOEF) m_shadow[idx] = d;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_active  = m_shadow;
    m_pending = 1'b1;
  endtask

  task automatic start_sample(input logic [SIG_W-1:0] src, input logic [SIG_W-1:0] resp);
    q_sig.push_back(src);
    q_resp.push_back(resp);
    q_sample.push_back(resp);
    if (m_pending) begin
      for (int i = 0; i < NCOEF; i++) begin
        q_coef.push_back(to_sm(m_active[i]));
        q_coef_cyc.push_back(cyc + 1 + i);
      end
      q_start_cyc.push_back(cyc + NCOEF + 1);
      m_pending = 1'b0;
    end else begin
      q_start_cyc.push_back(cyc + 1);
    end
    sample_stb = 1'b1; src_in = src;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      if (sample_valid === 1'b1) return;
      tick();
    end
    check("valid_timeout", sample_valid, 1);
  endtask

  task automatic do_sample(input logic [SIG_W-1:0] src, input logic [SIG_W-1:0] resp);
    start_sample(src, resp);
    wait_valid();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();

    // Plain sample, nothing committed.
    do_sample(16'h0100, 16'h1234);

    // Mixed signs, then a back-to-back sample in the valid cycle without reload.
    write(0, 10'h3F1);
    for (int i = 1; i < NCOEF; i++) write(i, 10'h00F);
    do_commit();
    start_sample(16'h0200, 16'h4321);
    wait_valid();
    start_sample(16'h0300, 16'h5555);
    wait_valid();
    tick();

    // Boundary values; commit in the same cycle as a write copies the old shadow.
    write(2, 10'h200);
    write(3, 10'h000);
    write(4, 10'h3FF);
    wr_en = 1'b1; wr_idx = 4'd5; wr_data = 10'h1FF; commit = 1'b1;
    m_active = m_shadow; m_pending = 1'b1; m_shadow[5] = 10'h1FF;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    do_sample(16'hFFFF, 16'h8000);
    do_commit();
    do_sample(16'h7FFF, 16'h0001);

    // Commit during LOAD is deferred until the load completes.
    write(0, 10'h001);
    do_commit();
    start_sample(16'h0A0A, 16'h0B0B);
    repeat (3) tick();
    write(0, 10'h1FF);
    write(6, 10'h3FE);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_valid();
    tick();
    m_active = m_shadow; m_pending = 1'b1;
    do_sample(16'h0C0C, 16'h0D0D);
    do_sample(16'h0E0E, 16'h0F0F);

    // Strobe while busy is dropped and sets a sticky overrun; idx 12 writes go nowhere.
    check("overrun_init", overrun, 0);
    start_sample(16'h1111, 16'h2222);
    tick();
    sample_stb = 1'b1; src_in = 16'h9999;
    tick();
    sample_stb = 1'b0;
    wait_valid();
    tick();
    check("overrun_set", overrun, 1);
    write(12, 10'h123);
    write(15, 10'h321);
    do_commit();
    do_sample(16'h3333, 16'h4444);
    check("overrun_sticky", overrun, 1);

    // filt_done while idle must not produce a sample.
    filt_done = 1'b1; filt_sig_out = 16'hBEEF;
    tick();
    filt_done = 1'b0; filt_sig_out = '0;
    tick();
    check("idle_done_busy", busy, 0);

    // Reset on load cycle 5 aborts the load and clears pending and banks.
    write(4, 10'h155);
    do_commit();
    start_sample(16'h5A5A, 16'h6B6B);
    repeat (4) tick();
    check("load_cycle5", coef_load, 1);
    do_reset();
    do_sample(16'h0042, 16'h0043);
    do_commit();
    do_sample(16'h0044, 16'h0045);

    repeat (3) tick();
    check("sb_coef_drained", q_coef.size(), 0);
    check("sb_start_drained", q_start_cyc.size(), 0);
    check("sb_sample_drained", q_sample.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
